// File: rtl/mmx_rep_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmx_rep_seq_if : decode / alu3 / writeback / ECX bundle for the REP  |
// |                  sequencer.                                          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface mmx_rep_seq_if #(
  parameter int W_OP = 5
);
  logic            start_v;
  logic            start_ready;
  logic [W_OP-1:0] start_op;
  logic            start_rep;
  logic [31:0]     ecx_in;
  logic [W_OP-1:0] alu3_op;
  logic [31:0]     ecx_out;
  logic [63:0]     alu_res3;
  logic            res_v;
  logic            res_ready;
  logic [63:0]     res_data;
  logic            res_last;
  logic            ecx_wr_v;
  logic [31:0]     ecx_wr_data;
  logic            flush;
  logic            done;
  logic            busy;

  modport slave (
    input  start_v, start_op, start_rep, ecx_in, alu_res3, res_ready, flush,
    output start_ready, alu3_op, ecx_out, res_v, res_data, res_last,
           ecx_wr_v, ecx_wr_data, done, busy
  );

  modport master (
    output start_v, start_op, start_rep, ecx_in, alu_res3, res_ready, flush,
    input  start_ready, alu3_op, ecx_out, res_v, res_data, res_last,
           ecx_wr_v, ecx_wr_data, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/mmx_rep_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmx_rep_seq : time-shares alu3 between the MMX body op and the ECX   |
// |               decrement so REP ops iterate without decode.           |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mmx_rep_seq #(
  parameter int              W_OP      = 5,
  parameter logic [W_OP-1:0] OP_ECXDEC = 5'b11000
) (
  input  logic         clk,
  input  logic         rst,
  mmx_rep_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2,
    S_DEC  = 2'd3
  } state_e;

  state_e          state_q;
  logic [W_OP-1:0] op_q;
  logic            rep_q;
  logic [31:0]     ecx_q;
  logic [63:0]     res_data_q;
  logic            res_v_q;
  logic            res_last_q;
  logic            done_q;
  logic [W_OP-1:0] alu3_op_q;

  // In DEC alu3 returns ECX-1 in the low word; that is the next ECX.
  logic [31:0] ecx_d;
  assign ecx_d = bus.alu_res3[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rep_q      <= 1'b0;
      ecx_q      <= '0;
      res_data_q <= '0;
      res_v_q    <= 1'b0;
      res_last_q <= 1'b0;
      done_q     <= 1'b0;
      alu3_op_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state_q   <= S_IDLE;
        res_v_q   <= 1'b0;
        alu3_op_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start_v) begin
              op_q  <= bus.start_op;
              rep_q <= bus.start_rep;
              ecx_q <= bus.ecx_in;
              // REP with ECX==0 retires immediately with no result.
              if (bus.start_rep && (bus.ecx_in == 32'd0)) begin
                done_q <= 1'b1;
              end else begin
                state_q   <= S_EXEC;
                alu3_op_q <= bus.start_op;
              end
            end
          end
          S_EXEC: begin
            res_data_q <= bus.alu_res3;
            res_v_q    <= 1'b1;
            res_last_q <= !rep_q || (ecx_q == 32'd1);
            alu3_op_q  <= '0;
            state_q    <= S_HOLD;
          end
          S_HOLD: begin
            if (bus.res_ready) begin
              res_v_q <= 1'b0;
              if (!rep_q) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_DEC;
                alu3_op_q <= OP_ECXDEC;
              end
            end
          end
          S_DEC: begin
            ecx_q <= ecx_d;
            if (ecx_d == 32'd0) begin
              state_q   <= S_IDLE;
              done_q    <= 1'b1;
              alu3_op_q <= '0;
            end else begin
              state_q   <= S_EXEC;
              alu3_op_q <= op_q;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            alu3_op_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.start_ready = (state_q == S_IDLE) && !bus.flush;
  assign bus.ecx_wr_v    = (state_q == S_DEC) && !bus.flush;
  assign bus.ecx_wr_data = bus.ecx_wr_v ? ecx_d : 32'd0;
  assign bus.alu3_op     = alu3_op_q;
  assign bus.ecx_out     = ecx_q;
  assign bus.res_v       = res_v_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_last    = res_last_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
